fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch stage, used when instruction memory has variable latency (req/ack handshake) instead of combinational read.
- Owns the PC, issues memory requests and captures responses into a one-entry skid buffer.
- Drives the fetch→decode register: pcD, instrD, validD.
- Applies decode back-pressure (stallD) and memory-stage redirects (redirectM/pcM), including discarding in-flight responses.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/fetch_skid.sv | 45 ++++
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants.
`ifndef WORD
`define WORD [31:0]
`endif

package pipeline_pkg;

    typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, instr} buffer holding a response that decode could not take.
`ifndef WORD
`define WORD [31:0]
`endif

module fetch_skid
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic `WORD  pc_i,
    input  logic `WORD  instr_i,
    output logic        valid_o,
    output logic `WORD  pc_o,
    output logic `WORD  instr_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    // An empty buffer always reads back as a NOP so its contents are safe to forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for variable-latency memory: owns the PC,
// the request handshake and the fetch->decode register.
//
// state | meaning
// BOOT  | first cycle after reset, no request yet
// REQ   | request for pc outstanding on imem
// HOLD  | decode stalled with a response parked in the skid buffer
// DRAIN | redirected while a request was in flight; waiting out its ack
`ifndef WORD
`define WORD [31:0]
`endif

module fetch_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallD,
    input  logic        redirectM,
    input  logic `WORD  pcM,
    output logic        imem_req,
    output logic `WORD  imem_addr,
    input  logic        imem_ack,
    input  logic `WORD  imem_rdata,
    output logic `WORD  pcD,
    output logic `WORD  instrD,
    output logic        validD
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_addr_q;
    logic         req_q;
    logic [31:0]  pcD_q;
    logic [31:0]  instrD_q;
    logic         validD_q;

    logic         dec_free;
    logic         ack;
    logic [31:0]  redirect_pc;
    logic [31:0]  pc_d;
    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_instr;

    assign dec_free    = !validD_q || !stallD;
    assign ack         = imem_ack && req_q;
    assign redirect_pc = align_word(pcM);
    assign pc_d        = pc_q + 32'd4;
    assign skid_load   = (state_q == REQ) && ack && !redirectM && !dec_free;
    assign skid_clear  = redirectM || ((state_q == HOLD) && !stallD);

    fetch_skid u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    // req_addr_q doubles as the latched address replayed while draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= align_word(RESET_PC);
            req_addr_q <= align_word(RESET_PC);
            req_q      <= 1'b0;
            pcD_q      <= 32'h0;
            instrD_q   <= NOP_INSTR;
            validD_q   <= 1'b0;
        end else begin
            if (validD_q && !stallD) begin
                validD_q <= 1'b0;
                instrD_q <= NOP_INSTR;
            end
            case (state_q)
                BOOT: begin
                    state_q    <= REQ;
                    req_q      <= 1'b1;
                    req_addr_q <= redirectM ? redirect_pc : pc_q;
                end
                REQ: begin
                    if (redirectM) begin
                        if (ack) begin
                            req_addr_q <= redirect_pc;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (ack) begin
                        pc_q       <= pc_d;
                        req_addr_q <= pc_d;
                        if (dec_free) begin
                            pcD_q    <= pc_q;
                            instrD_q <= imem_rdata;
                            validD_q <= 1'b1;
                        end else begin
                            state_q <= HOLD;
                            req_q   <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (redirectM) begin
                        state_q    <= REQ;
                        req_q      <= 1'b1;
                        req_addr_q <= redirect_pc;
                    end else if (!stallD) begin
                        pcD_q      <= skid_pc;
                        instrD_q   <= skid_instr;
                        validD_q   <= skid_valid;
                        state_q    <= REQ;
                        req_q      <= 1'b1;
                        req_addr_q <= pc_q;
                    end
                end
                DRAIN: begin
                    if (ack) begin
                        state_q    <= REQ;
                        req_addr_q <= redirectM ? redirect_pc : pc_q;
                    end
                end
                default: begin
                    state_q <= BOOT;
                    req_q   <= 1'b0;
                end
            endcase
            // Redirect flushes decode and wins over every load above.
            if (redirectM) begin
                pc_q     <= redirect_pc;
                validD_q <= 1'b0;
                instrD_q <= NOP_INSTR;
            end
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = req_addr_q;
    assign pcD       = pcD_q;
    assign instrD    = instrD_q;
    assign validD    = validD_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios push expected decode
// contents; a monitor pops them as decode consumes instructions.
`ifndef WORD
`define WORD [31:0]
`endif

module tb_fetch_ctrl;

    localparam logic [31:0] NOP_C = 32'h0000_0013;
    localparam logic [31:0] XORK  = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stallD;
    logic        redirectM;
    logic [31:0] pcM;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic        validD;

    int          checks = 0;
    int          errors = 0;
    int          lat = 0;
    int          cnt = 0;
    logic        dead = 1'b0;
    exp_t        q[$];
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (rst_n),
        .stallD     (stallD),
        .redirectM  (redirectM),
        .pcM        (pcM),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pcD        (pcD),
        .instrD     (instrD),
        .validD     (validD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = pc ^ XORK;
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        stallD    = 1'b0;
        redirectM = 1'b0;
        pcM       = 32'h0;
        lat       = 0;
        dead      = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_validD", 32'(validD), 32'd0);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_instrD", instrD, NOP_C);
        chk("queue_drained", 32'(q.size()), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    // Memory model: ack after lat waiting cycles, drops on req low or reset.
    always @(negedge clk) begin
        if (!rst_n || !imem_req) begin
            imem_ack = 1'b0;
            cnt = 0;
        end else if (cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = (dead && imem_addr == 32'h20) ? 32'h0000_DEAD : (imem_addr ^ XORK);
            cnt = 0;
        end else begin
            imem_ack = 1'b0;
            cnt++;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("req_held", 32'(imem_req), 32'd1);
                    chk("addr_stable", imem_addr, prev_addr);
                end
                if (!validD) chk("nop_when_idle", instrD, NOP_C);
                if (validD && !stallD) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr actual pc=%h instr=%h expected none", pcD, instrD);
                    end else begin
                        e = q.pop_front();
                        chk("sb_pcD", pcD, e.pc);
                        chk("sb_instrD", instrD, e.instr);
                    end
                end
                prev_pend = imem_req && !imem_ack;
                prev_addr = imem_addr;
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        stallD     = 1'b0;
        redirectM  = 1'b0;
        pcM        = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;

        // Streaming with single-cycle acks.
        do_reset();
        for (int i = 0; i < 8; i++) push(32'(i * 4));
        chk("boot_req", 32'(imem_req), 32'd0);
        tick();
        chk("s1_req", 32'(imem_req), 32'd1);
        chk("s1_addr0", imem_addr, 32'h0);
        chk("s1_valid_w1", 32'(validD), 32'd0);
        tick();
        chk("s1_valid_w2", 32'(validD), 32'd1);
        chk("s1_addr4", imem_addr, 32'h4);
        repeat (8) tick();
        stallD = 1'b1;

        // Three-cycle ack latency.
        do_reset();
        lat = 3;
        push(32'h0); push(32'h4); push(32'h8);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("s2_valid_pulse", 32'(validD), 32'((k == 5) || (k == 9) || (k == 13)));
            if (k <= 4) chk("s2_addr_wait", imem_addr, 32'h0);
        end
        stallD = 1'b1;

        // Decode and skid both full under a 5-cycle stall.
        do_reset();
        for (int i = 0; i < 5; i++) push(32'(i * 4));
        tick();
        tick();
        stallD = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            tick();
            chk("s3_hold_req", 32'(imem_req), 32'd0);
            chk("s3_frozen_pc", pcD, 32'h0);
            chk("s3_frozen_instr", instrD, XORK);
        end
        tick();
        stallD = 1'b0;
        tick();
        chk("s3_skid_pc", pcD, 32'h4);
        chk("s3_skid_valid", 32'(validD), 32'd1);
        repeat (4) tick();
        stallD = 1'b1;

        // Redirect while the request to 0x20 is outstanding.
        do_reset();
        dead = 1'b1;
        for (int i = 0; i < 8; i++) push(32'(i * 4));
        push(32'h100);
        repeat (9) tick();
        chk("s4_outstanding", imem_addr, 32'h20);
        lat = 2;
        redirectM = 1'b1;
        pcM = 32'h100;
        tick();
        redirectM = 1'b0;
        chk("s4_drain_addr", imem_addr, 32'h20);
        chk("s4_drain_req", 32'(imem_req), 32'd1);
        chk("s4_flush_valid", 32'(validD), 32'd0);
        tick();
        tick();
        chk("s4_new_addr", imem_addr, 32'h100);
        chk("s4_wait_valid", 32'(validD), 32'd0);
        tick();
        tick();
        chk("s4_wait_valid2", 32'(validD), 32'd0);
        tick();
        chk("s4_first_valid", 32'(validD), 32'd1);
        tick();
        stallD = 1'b1;

        // Redirect with ack in the same cycle while decode is stalled.
        do_reset();
        push(32'h0); push(32'h4); push(32'h200); push(32'h204);
        repeat (4) tick();
        stallD = 1'b1;
        redirectM = 1'b1;
        pcM = 32'h203;
        tick();
        redirectM = 1'b0;
        stallD = 1'b0;
        chk("s5_valid", 32'(validD), 32'd0);
        chk("s5_instr_nop", instrD, NOP_C);
        chk("s5_addr", imem_addr, 32'h200);
        chk("s5_req", 32'(imem_req), 32'd1);
        tick();
        chk("s5_pcD", pcD, 32'h200);
        tick();
        tick();
        stallD = 1'b1;

        // Reset asserted while draining.
        do_reset();
        lat = 3;
        tick();
        chk("s6_req", 32'(imem_req), 32'd1);
        redirectM = 1'b1;
        pcM = 32'h40;
        tick();
        redirectM = 1'b0;
        chk("s6_drain_addr", imem_addr, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_req", 32'(imem_req), 32'd0);
        chk("s6_async_valid", 32'(validD), 32'd0);
        chk("s6_async_pcD", pcD, 32'h0);
        chk("s6_async_instr", instrD, NOP_C);
        do_reset();
        push(32'h0); push(32'h4);
        tick();
        chk("s6_restart_addr", imem_addr, 32'h0);
        chk("s6_restart_req", 32'(imem_req), 32'd1);
        repeat (3) tick();
        stallD = 1'b1;

        // PC wraps past the top of the address space.
        do_reset();
        push(32'hFFFF_FFFC); push(32'h0);
        tick();
        redirectM = 1'b1;
        pcM = 32'hFFFF_FFFC;
        tick();
        redirectM = 1'b0;
        chk("s7_top_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("s7_wrap_addr", imem_addr, 32'h0);
        tick();
        tick();
        stallD = 1'b1;

        tick();
        tick();
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
